mantissa_divider: RTL and testbench

- Iterative restoring divider for W-bit floating-point mantissas; the inverse of the combinational mantissa product unit.
- Computes Q = floor(a·2^W / b) as a (W+1)-bit quotient, one quotient bit per clock, with a W-bit remainder and a sticky bit for the rounding stage.
- Sits in the FP divide path between exponent subtract and normalise/round.
- Valid/ready handshake on both the input and output sides.

---
 rtl/mantissa_divider.sv | 114 +++++++++++
 tb/tb_mantissa_divider.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mantissa_divider.sv
// Restoring mantissa divider: quo = floor(a*2^W / b), one quotient bit per clock.
// Result carries remainder, sticky, divide-by-zero and overflow flags.
module mantissa_divider #(
  parameter int W  = 24,
  parameter int CW = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a_man,
  input  logic [W-1:0] b_man,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   quo,
  output logic [W-1:0] rem,
  output logic         sticky,
  output logic         dz,
  output logic         ovf
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FLAG = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  pr;
  logic [W-1:0]  qacc;

  logic [W:0]    trial;
  logic [W:0]    diff;
  logic [W:0]    pr_nx;
  logic          ge;
  logic          zero_b;
  logic          big_a;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  assign zero_b = (b_man == '0);
  assign big_a  = ({1'b0, a_man} >= {b_man, 1'b0});

  // First step brings in all of a; later steps shift in the zero
  // fraction bits of a*2^W. Held remainder is always < b, so W bits.
  always_comb begin
    trial = {pr, 1'b0};
    if (cnt == CW'(W)) begin
      trial = {1'b0, a_q};
    end
    ge    = (trial >= {1'b0, b_q});
    diff  = trial - {1'b0, b_q};
    pr_nx = ge ? diff : trial;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      pr     <= '0;
      qacc   <= '0;
      quo    <= '0;
      rem    <= '0;
      sticky <= 1'b0;
      dz     <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q  <= a_man;
            b_q  <= b_man;
            pr   <= '0;
            qacc <= '0;
            cnt  <= CW'(W);
            dz   <= zero_b;
            ovf  <= !zero_b && big_a;
            state <= (zero_b || big_a) ? FLAG : RUN;
          end
        end
        RUN: begin
          pr   <= pr_nx[W-1:0];
          qacc <= {qacc[W-2:0], ge};
          if (cnt == '0) begin
            quo    <= {qacc, ge};
            rem    <= pr_nx[W-1:0];
            sticky <= |pr_nx;
            state  <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        FLAG: begin
          quo    <= '1;
          rem    <= '0;
          sticky <= 1'b0;
          state  <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mantissa_divider.sv
// Bench for mantissa_divider: vector table, hand sequences for reset/stall,
// and random operands against an arithmetic reference model.
module tb_mantissa_divider;

  localparam int W  = 24;
  localparam int CW = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a_man = '0;
  logic [W-1:0] b_man = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W:0]   quo;
  logic [W-1:0] rem;
  logic         sticky;
  logic         dz;
  logic         ovf;

  int total = 0;
  int passed = 0;

  mantissa_divider #(.W(W), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_man(a_man), .b_man(b_man),
    .out_valid(out_valid), .out_ready(out_ready),
    .quo(quo), .rem(rem), .sticky(sticky),
    .dz(dz), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   q;
    logic [W-1:0] r;
    logic         s;
    logic         dz;
    logic         ov;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic vec_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    vec_t v;
    longint unsigned n;
    longint unsigned d;
    v.a = a; v.b = b;
    v.q = '1; v.r = '0; v.s = 1'b0; v.dz = 1'b0; v.ov = 1'b0;
    n = longint'(a);
    d = longint'(b);
    if (d == 0) v.dz = 1'b1;
    else if (n >= 2 * d) v.ov = 1'b1;
    else begin
      n = n << W;
      v.q = (W+1)'(n / d);
      v.r = W'(n % d);
      v.s = (n % d) != 0;
    end
    return v;
  endfunction

  task automatic run_op(input vec_t v, input logic hold, input string tag);
    int n;
    int lat;
    lat = (v.dz || v.ov) ? 2 : W + 2;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " ready"}, 64'(in_ready), 64'(1));
    @(negedge clk);
    a_man = v.a; b_man = v.b;
    in_valid = 1'b1;
    out_ready = hold;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 1;
    while (n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (out_valid) break;
    end
    chk({tag, " latency"}, 64'(n), 64'(lat));
    chk({tag, " quo"}, 64'(quo), 64'(v.q));
    chk({tag, " rem"}, 64'(rem), 64'(v.r));
    chk({tag, " sticky"}, 64'(sticky), 64'(v.s));
    chk({tag, " dz"}, 64'(dz), 64'(v.dz));
    chk({tag, " ovf"}, 64'(ovf), 64'(v.ov));
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk({tag, " retired"}, 64'(out_valid), 64'(0));
    chk({tag, " idle"}, 64'(in_ready), 64'(1));
  endtask

  vec_t tbl[9];

  initial begin
    vec_t v;
    int n;
    logic [W-1:0] ra, rb;
    longint unsigned lim;

    tbl[0] = '{24'h800000, 24'h800000, 25'h1000000, 24'h0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{24'hCCCCCC, 24'hAAAAAA, 25'h1333333, 24'h222222, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{24'h555555, 24'hCCCCCC, 25'h06AAAAA, 24'h888888, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{24'hFFFFFF, 24'h800000, 25'h1FFFFFE, 24'h0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{24'h800000, 24'h400000, 25'h1FFFFFF, 24'h0, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{24'h9ABCDE, 24'h000000, 25'h1FFFFFF, 24'h0, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{24'hFFFFFF, 24'hFFFFFF, 25'h1000000, 24'h0, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{24'hFFFFFD, 24'h7FFFFF, 25'h1FFFFFD, 24'h7FFFFD, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{24'h000000, 24'h123456, 25'h0, 24'h0, 1'b0, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst in_ready", 64'(in_ready), 64'(1));
    chk("rst out_valid", 64'(out_valid), 64'(0));
    chk("rst quo", 64'(quo), 64'(0));
    chk("rst rem", 64'(rem), 64'(0));
    chk("rst flags", 64'({sticky, dz, ovf}), 64'(0));
    rst_n = 1'b1;

    // Abort a running divide with reset after 10 steps.
    @(negedge clk);
    a_man = 24'hCCCCCC; b_man = 24'hAAAAAA; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 64'(out_valid), 64'(0));
    chk("midrst in_ready", 64'(in_ready), 64'(1));
    chk("midrst quo", 64'(quo), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      run_op(tbl[i], i == 3, $sformatf("vec%0d", i));

    // Stall the consumer; new operands during DONE must be ignored.
    v = model(24'h9ABCDE, 24'hABCDEF);
    @(negedge clk);
    a_man = v.a; b_man = v.b; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("stall reached done", 64'(out_valid), 64'(1));
    for (int k = 0; k < 5; k++) begin
      a_man = 24'h000001; b_man = 24'h000001; in_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("stall%0d quo", k), 64'(quo), 64'(v.q));
      chk($sformatf("stall%0d rem", k), 64'(rem), 64'(v.r));
      chk($sformatf("stall%0d busy", k), 64'({out_valid, in_ready}), 64'(2));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("stall retire idle", 64'({out_valid, in_ready}), 64'(1));
    chk("stall quo kept", 64'(quo), 64'(v.q));

    for (int k = 0; k < 40; k++) begin
      rb = W'($urandom);
      if ($urandom_range(0, 3) != 0) rb[W-1] = 1'b1;
      lim = 2 * longint'(rb);
      ra = W'($urandom);
      if ($urandom_range(0, 9) == 0) rb = '0;
      else if ($urandom_range(0, 9) != 0 && lim != 0 && lim <= (64'd1 << W))
        ra = W'(longint'(ra) % lim);
      if (k == 0) begin
        rb = 24'h812345;
        ra = W'(2 * longint'(rb) - 1);
      end
      run_op(model(ra, rb), k[0], $sformatf("rnd%0d", k));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
